// File: rtl/motor_pwm_multiphase.sv
// motor_pwm_multiphase: center-aligned multi-phase motor PWM with an internal
// period counter, complementary outputs with deadband, shadowed period/duty/
// deadband updates at period boundaries, and a fault input forcing the safe
// state (P low, N high).
// Optional build macro MOTOR_PWM_FAULT_LATCH_EN: fault is sticky until
// iFAULT_CLR is pulsed while iFAULT is low.
`timescale 1ns/1ps

module motor_pwm_multiphase #(
  parameter int unsigned SIZE   = 16,
  parameter int unsigned PHASES = 3
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iENABLE,
  input  logic [SIZE-1:0]          iPERIOD,
  input  logic [PHASES*SIZE-1:0]   iDUTY,
  input  logic [SIZE-1:0]          iDEADBAND,
  input  logic                     iLOAD,
  input  logic                     iFAULT,
  input  logic                     iFAULT_CLR,
  output logic [PHASES-1:0]        oPAD_P,
  output logic [PHASES-1:0]        oPAD_N,
  output logic [SIZE-1:0]          oCOUNTER,
  output logic                     oSYNC,
  output logic                     oFAULT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] ONE = SIZE'(1);
  localparam logic [SIZE-1:0] TWO = SIZE'(2);

  state_t state;
  state_t nextState;

  logic [SIZE-1:0]        cnt;
  logic [SIZE-1:0]        activePeriod;
  logic [SIZE-1:0]        activeDeadband;
  logic [PHASES*SIZE-1:0] activeDuty;
  logic [SIZE-1:0]        shadowPeriod;
  logic [SIZE-1:0]        shadowDeadband;
  logic [PHASES*SIZE-1:0] shadowDuty;
  logic                   pending;

  logic periodOk;
  logic wrapEdge;
  logic runEntry;
  logic runStay;

  logic [SIZE:0] edgeA [PHASES];
  logic [SIZE:0] edgeB [PHASES];
  logic [SIZE:0] edgeC [PHASES];
  logic [SIZE:0] edgeD [PHASES];
  logic [SIZE:0] dutyC [PHASES];

  logic [PHASES-1:0] padPNext;
  logic [PHASES-1:0] padNNext;

`ifndef MOTOR_PWM_FAULT_LATCH_EN
  logic unusedFaultClr;
  assign unusedFaultClr = iFAULT_CLR;
`endif

  // Period qualification and boundary detection.
  // A stalled counter (period < 2) treats every cycle as a boundary so a
  // pending load can still bring the period back into range.
  always_comb begin
    periodOk = (activePeriod >= TWO);
    runEntry = (state != RUN) && (nextState == RUN);
    runStay  = (state == RUN) && (nextState == RUN);
    wrapEdge = 1'b0;
    if (state == RUN) begin
      wrapEdge = periodOk ? (cnt == (activePeriod - ONE)) : 1'b1;
    end
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; fault takes priority over the run request.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (iFAULT) begin
          nextState = FAULT;
        end else if (iENABLE) begin
          nextState = RUN;
        end
      end
      RUN: begin
        if (iFAULT) begin
          nextState = FAULT;
        end else if (!iENABLE) begin
          nextState = IDLE;
        end
      end
      FAULT: begin
`ifdef MOTOR_PWM_FAULT_LATCH_EN
        if (iFAULT_CLR && !iFAULT) begin
          nextState = IDLE;
        end
`else
        if (!iFAULT) begin
          nextState = IDLE;
        end
`endif
      end
      default: nextState = IDLE;
    endcase
  end

  // Status outputs decoded from state and counter.
  always_comb begin
    oFAULT   = (state == FAULT);
    oSYNC    = (state == RUN) && periodOk && (cnt == '0);
    oCOUNTER = cnt;
  end

  // Shadow capture, boundary transfer, direct load on RUN entry, and counter.
  // A load on the wrap edge is ordered after the transfer so the older shadow
  // moves to the active set while the new capture stays pending.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      cnt            <= '0;
      activePeriod   <= '0;
      activeDeadband <= '0;
      activeDuty     <= '0;
      shadowPeriod   <= '0;
      shadowDeadband <= '0;
      shadowDuty     <= '0;
      pending        <= 1'b0;
    end else begin
      if (wrapEdge && pending) begin
        activePeriod   <= shadowPeriod;
        activeDeadband <= shadowDeadband;
        activeDuty     <= shadowDuty;
        pending        <= 1'b0;
      end
      if (iLOAD) begin
        shadowPeriod   <= iPERIOD;
        shadowDeadband <= iDEADBAND;
        shadowDuty     <= iDUTY;
        pending        <= 1'b1;
      end
      if (runEntry) begin
        activePeriod   <= iPERIOD;
        activeDeadband <= iDEADBAND;
        activeDuty     <= iDUTY;
      end

      if (!runStay || !periodOk || wrapEdge) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  // Per-phase switching edges in SIZE+1 bits so the sums never wrap.
  always_comb begin
    edgeA    = '{default: '0};
    edgeB    = '{default: '0};
    edgeC    = '{default: '0};
    edgeD    = '{default: '0};
    dutyC    = '{default: '0};
    padPNext = '0;
    padNNext = '1;
    for (int unsigned k = 0; k < PHASES; k++) begin
      if ({1'b0, activeDuty[k*SIZE +: SIZE]} > {1'b0, activePeriod}) begin
        dutyC[k] = {1'b0, activePeriod};
      end else begin
        dutyC[k] = {1'b0, activeDuty[k*SIZE +: SIZE]};
      end
      edgeA[k] = ({1'b0, activePeriod} - dutyC[k]) >> 1;
      edgeB[k] = edgeA[k] + {1'b0, activeDeadband};
      edgeC[k] = edgeA[k] + dutyC[k];
      edgeD[k] = edgeC[k] + {1'b0, activeDeadband};
      padNNext[k] = ({1'b0, cnt} < edgeA[k]) || ({1'b0, cnt} > edgeD[k]);
      padPNext[k] = ({1'b0, cnt} >= edgeB[k]) && ({1'b0, cnt} <= edgeC[k]);
    end
  end

  // Pad register; safe state whenever the coming cycle is not a valid RUN cycle.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oPAD_P <= '0;
      oPAD_N <= '1;
    end else if (runStay && periodOk) begin
      oPAD_P <= padPNext;
      oPAD_N <= padNNext;
    end else begin
      oPAD_P <= '0;
      oPAD_N <= '1;
    end
  end

endmodule

// File: tb/tb_motor_pwm_multiphase.sv
// Directed testbench for motor_pwm_multiphase (SIZE=16, PHASES=3, period 100).
`timescale 1ns/1ps

module tb_motor_pwm_multiphase;

  localparam int unsigned SIZE   = 16;
  localparam int unsigned PHASES = 3;

  logic                   iCLK = 1'b0;
  logic                   iRESET;
  logic                   iENABLE;
  logic [SIZE-1:0]        iPERIOD;
  logic [PHASES*SIZE-1:0] iDUTY;
  logic [SIZE-1:0]        iDEADBAND;
  logic                   iLOAD;
  logic                   iFAULT;
  logic                   iFAULT_CLR;
  logic [PHASES-1:0]      oPAD_P;
  logic [PHASES-1:0]      oPAD_N;
  logic [SIZE-1:0]        oCOUNTER;
  logic                   oSYNC;
  logic                   oFAULT;

  int testCount = 0;
  int failCount = 0;

  // Expected bands per phase: N low for gLo..gHi, P high for pLo..pHi.
  int unsigned gLo [PHASES];
  int unsigned pLo [PHASES];
  int unsigned pHi [PHASES];
  int unsigned gHi [PHASES];
  int unsigned expPeriod = 100;

  motor_pwm_multiphase #(
    .SIZE  (SIZE),
    .PHASES(PHASES)
  ) dut (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iENABLE   (iENABLE),
    .iPERIOD   (iPERIOD),
    .iDUTY     (iDUTY),
    .iDEADBAND (iDEADBAND),
    .iLOAD     (iLOAD),
    .iFAULT    (iFAULT),
    .iFAULT_CLR(iFAULT_CLR),
    .oPAD_P    (oPAD_P),
    .oPAD_N    (oPAD_N),
    .oCOUNTER  (oCOUNTER),
    .oSYNC     (oSYNC),
    .oFAULT    (oFAULT)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic setBand(input int unsigned k, input int unsigned a, input int unsigned b,
                         input int unsigned c, input int unsigned d);
    gLo[k] = a;
    pLo[k] = b;
    pHi[k] = c;
    gHi[k] = d;
  endtask

  task automatic setAllBands(input int unsigned a, input int unsigned b,
                             input int unsigned c, input int unsigned d);
    for (int k = 0; k < PHASES; k++) setBand(k, a, b, c, d);
  endtask

  function automatic logic [5:0] expPads(input int unsigned c);
    logic [2:0] p;
    logic [2:0] n;
    for (int k = 0; k < PHASES; k++) begin
      p[k] = (c >= pLo[k]) && (c <= pHi[k]);
      n[k] = !((c >= gLo[k]) && (c <= gHi[k]));
    end
    return {p, n};
  endfunction

  // Each cycle: pads reflect the previous counter value, counter advances
  // modulo the period, sync marks counter zero.
  task automatic runCycles(input string tag, input int n);
    int unsigned prev;
    int unsigned nxt;
    for (int i = 0; i < n; i++) begin
      prev = oCOUNTER;
      nxt  = (prev == expPeriod - 1) ? 0 : prev + 1;
      tick();
      check($sformatf("%s pads c=%0d", tag, prev), {26'd0, oPAD_P, oPAD_N}, {26'd0, expPads(prev)});
      check($sformatf("%s cnt c=%0d", tag, prev), {16'd0, oCOUNTER}, nxt);
      check($sformatf("%s sync c=%0d", tag, prev), {31'd0, oSYNC}, {31'd0, (nxt == 0)});
    end
  endtask

  task automatic checkSafe(input string tag, input logic expFault, input logic expSync);
    check({tag, " P"}, {29'd0, oPAD_P}, 32'd0);
    check({tag, " N"}, {29'd0, oPAD_N}, 32'd7);
    check({tag, " cnt"}, {16'd0, oCOUNTER}, 32'd0);
    check({tag, " sync"}, {31'd0, oSYNC}, {31'd0, expSync});
    check({tag, " fault"}, {31'd0, oFAULT}, {31'd0, expFault});
  endtask

  initial begin
    iRESET     = 1'b1;
    iENABLE    = 1'b0;
    iPERIOD    = '0;
    iDUTY      = '0;
    iDEADBAND  = '0;
    iLOAD      = 1'b0;
    iFAULT     = 1'b0;
    iFAULT_CLR = 1'b0;
    @(negedge iCLK);
    tick();
    tick();
    checkSafe("reset", 1'b0, 1'b0);

    // Basic run: period 100, duty 40 on all phases, deadband 5.
    iPERIOD   = 16'd100;
    iDUTY     = {16'd40, 16'd40, 16'd40};
    iDEADBAND = 16'd5;
    iENABLE   = 1'b1;
    iRESET    = 1'b0;
    tick();
    checkSafe("entry", 1'b0, 1'b1);
    setAllBands(30, 35, 70, 75);
    runCycles("d40", 198);

    // Per-phase duties {0,50,100} loaded at cnt 98, active after the wrap.
    iDUTY = {16'd100, 16'd50, 16'd0};
    iLOAD = 1'b1;
    runCycles("ld98", 1);
    iLOAD = 1'b0;
    runCycles("wrap98", 1);
    setBand(0, 50, 55, 50, 55);
    setBand(1, 25, 30, 75, 80);
    setBand(2, 0, 5, 100, 105);
    runCycles("mix", 100);

    // Mid-period load at cnt 37: old edges hold until the wrap.
    runCycles("mix2", 37);
    iDUTY = {16'd60, 16'd60, 16'd60};
    iLOAD = 1'b1;
    runCycles("ld37", 1);
    iLOAD = 1'b0;
    runCycles("old37", 62);
    setAllBands(20, 25, 80, 85);
    runCycles("d60", 100);

    // Load exactly on the wrap edge: takes effect one period later.
    runCycles("d60b", 99);
    iDUTY = {16'd40, 16'd40, 16'd40};
    iLOAD = 1'b1;
    runCycles("ld99", 1);
    iLOAD = 1'b0;
    runCycles("hold60", 100);
    setAllBands(30, 35, 70, 75);
    runCycles("d40b", 100);

    // Fault at cnt 50.
    runCycles("prefault", 50);
    iFAULT = 1'b1;
    tick();
    checkSafe("fault", 1'b1, 1'b0);
    iFAULT = 1'b0;
    tick();
`ifdef MOTOR_PWM_FAULT_LATCH_EN
    checkSafe("fault sticky", 1'b1, 1'b0);
    iFAULT_CLR = 1'b1;
    tick();
    iFAULT_CLR = 1'b0;
`endif
    checkSafe("fault idle", 1'b0, 1'b0);
    tick();
    checkSafe("restart", 1'b0, 1'b1);
    runCycles("postfault", 100);

    // Enable dropped at cnt 20, then re-enabled with new inputs (no iLOAD).
    runCycles("preidle", 20);
    iENABLE = 1'b0;
    tick();
    checkSafe("disable", 1'b0, 1'b0);
    iDUTY = {16'd50, 16'd50, 16'd50};
    tick();
    checkSafe("idle", 1'b0, 1'b0);
    iENABLE = 1'b1;
    tick();
    checkSafe("reenable", 1'b0, 1'b1);
    setAllBands(25, 30, 75, 80);
    runCycles("d50", 100);

    // Reset mid-period with fault held.
    runCycles("prereset", 40);
    iRESET = 1'b1;
    iFAULT = 1'b1;
    tick();
    checkSafe("rst fault", 1'b0, 1'b0);
    iRESET = 1'b0;
    tick();
    checkSafe("refault", 1'b1, 1'b0);
    iFAULT = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
